// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: two-flop synchroniser, per-bit debounce, write-1-to-clear
// edge capture and a masked, registered level interrupt.
module pio_in_edge_irq #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000,
    parameter int unsigned      EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edge_det_c;
    logic [WIDTH-1:0] clear_c;
    logic [WIDTH-1:0] wdata_c;
    logic [31:0]      rd_mux_c;
    logic             wr_en_c;
    logic             unused_wdata;

    assign wr_en_c      = chipselect & ~write_n;
    assign wdata_c      = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    // Metastability guard on the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= RESET_LEVEL;
            s2 <= RESET_LEVEL;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end

    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                deb <= RESET_LEVEL;
            end else begin
                deb <= s2;
            end
        end
    end else begin : g_debounce
        localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
        localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

        logic [CNT_W-1:0] cnt [WIDTH];

        // A bit follows s2 only after it has differed from deb for DEBOUNCE_CYCLES cycles.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    cnt[i] <= '0;
                end
                deb <= RESET_LEVEL;
            end else begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    if (s2[i] == deb[i]) begin
                        cnt[i] <= '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        deb[i] <= s2[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        edge_det_c = '0;
        case (EDGE_TYPE)
            32'd0:   edge_det_c = ~deb_d & deb;
            32'd1:   edge_det_c = deb_d & ~deb;
            default: edge_det_c = deb_d ^ deb;
        endcase
    end

    assign clear_c = (wr_en_c && address == ADDR_EDGE) ? wdata_c : '0;

    always_comb begin
        rd_mux_c = '0;
        case (address)
            ADDR_DATA: rd_mux_c = 32'(deb);
            ADDR_MASK: rd_mux_c = 32'(irqmask);
            ADDR_EDGE: rd_mux_c = 32'(edgecapture);
            default:   rd_mux_c = '0;
        endcase
    end

    // Edge detected in the same cycle as a clear wins, so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_d       <= RESET_LEVEL;
            edgecapture <= '0;
            irqmask     <= '0;
            irq         <= 1'b0;
            readdata    <= '0;
        end else begin
            deb_d       <= deb;
            edgecapture <= (edgecapture & ~clear_c) | edge_det_c;
            if (wr_en_c && address == ADDR_MASK) begin
                irqmask <= wdata_c;
            end
            irq      <= |(edgecapture & irqmask);
            readdata <= rd_mux_c;
        end
    end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench: a debounced falling-edge instance driven from a vector table,
// plus a bypassed any-edge instance for the set/clear collision and mask width.
module tb_pio_in_edge_irq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs_a;
    logic        cs_b;
    logic [3:0]  in_a;
    logic [3:0]  in_b;
    logic [31:0] rd_a;
    logic [31:0] rd_b;
    logic        irq_a;
    logic        irq_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pio_in_edge_irq #(
        .WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_LEVEL(4'hF)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
        .write_n(write_n), .writedata(writedata), .in_port(in_a),
        .readdata(rd_a), .irq(irq_a)
    );

    pio_in_edge_irq #(
        .WIDTH(4), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2), .RESET_LEVEL(4'h0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
        .write_n(write_n), .writedata(writedata), .in_port(in_b),
        .readdata(rd_b), .irq(irq_b)
    );

    typedef struct {
        logic [3:0]  in_v;
        logic [1:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [3:0] in_v, input logic [1:0] addr,
                                input logic wr, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic exp_irq);
        vec_t v;
        v.in_v = in_v; v.addr = addr; v.wr = wr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; address = 2'd0; write_n = 1'b1; writedata = '0;
        cs_a = 1'b0; cs_b = 1'b0; in_a = 4'hF; in_b = 4'h0;

        // Row k: inputs applied before edge k, outputs checked just after it.
        add(4'hF, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        add(4'hF, 2'd1, 1'b0, 32'h0, 32'h0, 1'b0);
        add(4'hF, 2'd2, 1'b1, 32'h1, 32'h0, 1'b0);
        add(4'hF, 2'd2, 1'b0, 32'h0, 32'h1, 1'b0);
        add(4'hF, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        // 3-cycle glitch on bit1 must be rejected
        for (int i = 0; i < 3; i++) add(4'hD, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        for (int i = 0; i < 3; i++) add(4'hF, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        add(4'hF, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        // clean press of bit0: deb falls on the 6th edge, visible on the 7th
        for (int i = 0; i < 6; i++) add(4'hE, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        add(4'hE, 2'd0, 1'b0, 32'h0, 32'hE, 1'b0);
        add(4'hE, 2'd3, 1'b0, 32'h0, 32'h1, 1'b1);
        add(4'hE, 2'd3, 1'b1, 32'h1, 32'h1, 1'b1);
        add(4'hE, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        // release bit0 with mask cleared; rising edge is not captured
        add(4'hF, 2'd2, 1'b1, 32'h0, 32'h1, 1'b0);
        for (int i = 0; i < 5; i++) add(4'hF, 2'd0, 1'b0, 32'h0, 32'hE, 1'b0);
        add(4'hF, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        add(4'hF, 2'd3, 1'b0, 32'h0, 32'h0, 1'b0);
        // press bit1 with mask 0, then enable the mask
        for (int i = 0; i < 6; i++) add(4'hD, 2'd0, 1'b0, 32'h0, 32'hF, 1'b0);
        add(4'hD, 2'd0, 1'b0, 32'h0, 32'hD, 1'b0);
        add(4'hD, 2'd3, 1'b0, 32'h0, 32'h2, 1'b0);
        add(4'hD, 2'd2, 1'b1, 32'h2, 32'h0, 1'b0);
        add(4'hD, 2'd3, 1'b0, 32'h0, 32'h2, 1'b1);

        repeat (3) tick();
        check("reset_rd_a", rd_a, 32'h0);
        check("reset_irq_a", 32'(irq_a), 32'h0);
        check("reset_rd_b", rd_b, 32'h0);
        reset_n = 1'b1;

        cs_a = 1'b1;
        foreach (vecs[i]) begin
            in_a      = vecs[i].in_v;
            address   = vecs[i].addr;
            write_n   = ~vecs[i].wr;
            writedata = vecs[i].wdata;
            tick();
            check($sformatf("vec%0d_rd", i), rd_a, vecs[i].exp_rd);
            check($sformatf("vec%0d_irq", i), 32'(irq_a), 32'(vecs[i].exp_irq));
        end
        cs_a = 1'b0; write_n = 1'b1; writedata = '0;

        // Bypass instance: rising edge on bit2 captured on the 4th edge
        address = 2'd3; in_b = 4'h4;
        tick(); check("b_cap_e1", rd_b, 32'h0);
        tick(); tick();
        tick(); check("b_cap_e4", rd_b, 32'h0);
        tick(); check("b_cap_e5", rd_b, 32'h4);

        cs_b = 1'b1; write_n = 1'b0; writedata = 32'hB;
        tick(); write_n = 1'b1;
        tick(); check("b_w1c_zero_bits", rd_b, 32'h4);
        write_n = 1'b0; writedata = 32'h4;
        tick(); write_n = 1'b1;
        tick(); check("b_w1c_clear", rd_b, 32'h0);

        // Falling edge on bit2 with its clear landing on the capture edge
        in_b = 4'h0;
        tick(); tick(); tick();
        write_n = 1'b0; writedata = 32'h4;
        tick(); write_n = 1'b1;
        tick(); check("b_set_wins", rd_b, 32'h4);
        tick(); check("b_set_holds", rd_b, 32'h4);

        address = 2'd2; write_n = 1'b0; writedata = 32'hFFFF_FFF5;
        tick(); write_n = 1'b1;
        tick(); check("b_mask_upper_ignored", rd_b, 32'h5);
        check("b_irq", 32'(irq_b), 32'h1);
        cs_b = 1'b0;

        // Reset while bit0 of instance A is mid-debounce
        address = 2'd0; in_a = 4'hC;
        repeat (4) tick();
        #2 reset_n = 1'b0;
        #1;
        check("a_async_reset_rd", rd_a, 32'h0);
        check("a_async_reset_irq", 32'(irq_a), 32'h0);
        in_a = 4'hF;
        tick(); tick();
        check("a_reset_held_rd", rd_a, 32'h0);
        reset_n = 1'b1;
        repeat (10) tick();
        check("a_post_reset_data", rd_a, 32'hF);
        address = 2'd3;
        tick(); check("a_no_edge_after_reset", rd_a, 32'h0);
        address = 2'd2;
        tick(); check("a_mask_after_reset", rd_a, 32'h0);
        check("a_irq_after_reset", 32'(irq_a), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised Avalon-MM input PIO, successor to the single-bit key/switch input ports on the SoC.
- Synchronises and debounces WIDTH input pins and exposes the debounced level.
- Captures per-bit edges into a write-1-to-clear register and raises a maskable level interrupt to the Nios II.
- Sits on the lightweight Avalon bus next to the existing PIOs; drives KEY/SW inputs and the CPU irq line.

Parameters:
- WIDTH, 4, number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced level changes (0 = debounce bypassed).
- EDGE_TYPE, 0, edges captured: 0 = rising, 1 = falling, 2 = any.
- RESET_LEVEL, 0, WIDTH-bit reset value of the synchroniser and debounced registers (use all-ones for active-low keys).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data; bits above WIDTH ignored.
- in_port  in  WIDTH  asynchronous pin inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.

Behaviour:
- Reset:
  - readdata = 0, edgecapture = 0, irqmask = 0, all debounce counters = 0.
  - sync stage 1, sync stage 2 and deb = RESET_LEVEL.
  - irq = 0.
  - All of the above apply immediately on reset_n low, mid-operation included.
- Synchroniser: two flops per bit (s1, s2); s2 lags in_port by 2 clk edges.
- Debounce, per bit, when DEBOUNCE_CYCLES > 0:
  - If s2 == deb: counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while s2 != deb, then deb <= s2 and the counter clears.
  - Any bounce back to s2 == deb before that point clears the counter, so no change occurs.
  - Counter width is clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Debounce bypass (DEBOUNCE_CYCLES = 0): deb <= s2 every cycle.
- Edge detection: compares deb with its value one cycle earlier (deb_d).
  - Rising edge: ~deb_d & deb.
  - Falling edge: deb_d & ~deb.
  - Any edge: the XOR of the two.
- Register map (word address; every register is zero-extended to 32 bits):
  - 0 data: RO, returns deb. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 irqmask: RW, WIDTH bits.
  - 3 edgecapture: read returns the captured bits. A write clears each bit whose writedata bit is 1.
- Write qualification: a write takes effect on a clk edge with chipselect = 1 and write_n = 0.
- Read path:
  - readdata <= mux(address) on every clk edge, independent of chipselect.
  - Read latency is 1 cycle.
  - A read of edgecapture has no side effect.
- Edgecapture set/clear:
  - A bit is set the cycle after its edge condition is true and stays set until cleared.
  - A detected edge and a write-1-clear of the same bit in the same cycle: set wins, and the bit stays 1.
  - Write-1 to a bit that is already 0 leaves it at 0.
- irq: registered, irq <= |(edgecapture & irqmask). It asserts 1 cycle after a masked bit sets or the mask is enabled, and deasserts 1 cycle after a clear.
- Widths: WIDTH = 32 uses the full word. Nothing wraps or overflows.

Test Plan:
- Reset value of data: WIDTH=4, RESET_LEVEL=4'hF, DEBOUNCE_CYCLES=4, in_port=4'hF held. Release reset and read address 0 → readdata=32'h0000000F; irq=0.
- Debounce on a clean press: drive in_port[0] 1→0 and hold. data bit0 reads 0 exactly 2+4 cycles after the change; no change before that.
- Bounce rejection: pulse in_port[1] low for 3 cycles, then high (DEBOUNCE_CYCLES=4) → data stays 4'hF; edgecapture stays 0.
- Falling edge and interrupt: EDGE_TYPE=1, irqmask=4'h1, then press bit0.
  - Required: edgecapture=4'h1, and irq=1 two cycles after deb falls.
  - Then write 32'h1 to address 3 → edgecapture=0 and irq=0 one cycle later.
- Set-wins collision: use DEBOUNCE_CYCLES=0 and time the write-1-clear of bit2 to the same cycle bit2's edge is detected → edgecapture bit2=1 afterwards.
- Mask gating and reset mid-debounce:
  - With edgecapture=4'h2 and irqmask=0 → irq=0. Write irqmask=4'h2 → irq=1 next cycle.
  - Assert reset_n while a counter is mid-count → all registers return to reset values immediately; no edge is captured after release.
